// File: rtl/approx_error_monitor.sv
// Error-metric stage for N-bit approximate adders: compares each sample against the
// exact modular sum and accumulates error count, max and saturating total error distance.
module approx_error_monitor #(
  parameter int N     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [N-1:0]     max_ed,
  output logic [ACC_W-1:0] sum_ed,
  output logic [CNT_W-1:0] samples_seen
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] seen_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;

  logic             s1_valid_q;
  logic [N-1:0]     s1_ed_q;
  logic             s1_err_q;

  logic [CNT_W-1:0] err_count_q;
  logic [N-1:0]     max_ed_q;
  logic [ACC_W-1:0] sum_ed_q;

  logic             accept_d;
  logic             start_acc_d;
  logic             last_d;
  logic [N-1:0]     exact_d;
  logic [N-1:0]     ed_d;
  logic [ACC_W:0]   sum_wide_d;
  logic [ACC_W-1:0] sum_sat_d;

  assign accept_d    = in_valid && in_ready_q;
  assign start_acc_d = (state_q == S_IDLE) && start;
  assign last_d      = accept_d && ((seen_q + 1'b1) == target_q);

  // Carry-out is dropped on purpose: the adder under test only produces N bits.
  assign exact_d = a + b;
  assign ed_d    = (exact_d >= approx_sum) ? (exact_d - approx_sum) : (approx_sum - exact_d);

  assign sum_wide_d = {1'b0, sum_ed_q} + {{(ACC_W + 1 - N){1'b0}}, s1_ed_q};
  assign sum_sat_d  = sum_wide_d[ACC_W] ? {ACC_W{1'b1}} : sum_wide_d[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      seen_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            seen_q <= '0;
            if (num_samples != '0) begin
              target_q   <= num_samples;
              state_q    <= S_RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept_d) begin
            seen_q <= seen_q + 1'b1;
          end
          if (last_d) begin
            state_q    <= S_DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 captures the error distance; stage 2 folds it into the run metrics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_ed_q     <= '0;
      s1_err_q    <= 1'b0;
      err_count_q <= '0;
      max_ed_q    <= '0;
      sum_ed_q    <= '0;
    end else begin
      s1_valid_q <= accept_d;
      if (accept_d) begin
        s1_ed_q  <= ed_d;
        s1_err_q <= (ed_d != '0);
      end
      if (start_acc_d) begin
        err_count_q <= '0;
        max_ed_q    <= '0;
        sum_ed_q    <= '0;
      end else if (s1_valid_q) begin
        err_count_q <= err_count_q + {{(CNT_W - 1){1'b0}}, s1_err_q};
        if (s1_ed_q > max_ed_q) begin
          max_ed_q <= s1_ed_q;
        end
        sum_ed_q <= sum_sat_d;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_count    = err_count_q;
  assign max_ed       = max_ed_q;
  assign sum_ed       = sum_ed_q;
  assign samples_seen = seen_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: a 24-bit and an 8-bit accumulator instance share stimulus
// and are compared against an arithmetic reference of the error metrics.
module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0, b = '0, approx_sum = '0;

  logic        in_ready, busy, done;
  logic [15:0] err_count, samples_seen;
  logic [7:0]  max_ed;
  logic [23:0] sum_ed;
  logic        in_ready_s, busy_s, done_s;
  logic [15:0] err_count_s, samples_seen_s;
  logic [7:0]  max_ed_s;
  logic [7:0]  sum_ed_s;

  approx_error_monitor #(.N(8), .CNT_W(16), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
    .busy(busy), .done(done), .err_count(err_count), .max_ed(max_ed),
    .sum_ed(sum_ed), .samples_seen(samples_seen)
  );

  approx_error_monitor #(.N(8), .CNT_W(16), .ACC_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .approx_sum(approx_sum),
    .busy(busy_s), .done(done_s), .err_count(err_count_s), .max_ed(max_ed_s),
    .sum_ed(sum_ed_s), .samples_seen(samples_seen_s)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Sample tables consumed in order by accepted samples; vpat overrides random in_valid.
  logic [7:0] qa[$], qb[$], qap[$];
  int         vpat[$];

  // Reference metrics of the accepted samples.
  int m_err, m_max, m_sum, m_acc;
  // Observations made while a run is driven.
  int o_proto_bad, o_done_pulses, o_lat, o_timeout;

  function automatic int exp_sum(input int bits);
    int lim = (1 << bits) - 1;
    return (m_sum > lim) ? lim : m_sum;
  endfunction

  task automatic drive_run(input int n, input int gap_pct, input int inject_cyc);
    int  acc = 0;
    int  idx = 0;
    int  pi = 0;
    int  last = (n == 0) ? -1 : -10;
    int  cyc;
    bit  v, e_rdy, e_busy, e_done;
    int  ex, ed;
    m_err = 0; m_max = 0; m_sum = 0; m_acc = 0;
    o_proto_bad = 0; o_done_pulses = 0; o_lat = -1; o_timeout = 1;
    @(negedge clk);
    start = 1'b1; num_samples = 16'(n); in_valid = 1'b0;
    for (cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = (cyc == inject_cyc);
      if (start) num_samples = 16'd7;
      e_rdy  = (acc < n);
      e_busy = (acc < n) || (cyc == last + 1);
      e_done = (acc == n) && (cyc == last + 2);
      if (in_ready !== e_rdy || in_ready_s !== e_rdy) o_proto_bad++;
      if (busy !== e_busy || busy_s !== e_busy) o_proto_bad++;
      if (done !== e_done || done_s !== e_done) o_proto_bad++;
      if (samples_seen !== 16'(acc) || samples_seen_s !== 16'(acc)) o_proto_bad++;
      if (done === 1'b1) begin
        o_done_pulses++;
        o_lat = cyc - last;
      end
      if (acc == n && cyc >= last + 5) begin
        o_timeout = 0;
        break;
      end
      if (acc < n) begin
        if (pi < vpat.size()) v = (vpat[pi++] != 0);
        else v = ($urandom_range(99) >= gap_pct);
      end else begin
        v = 1'b1;
      end
      in_valid = v;
      if (v && acc < n && idx < qa.size()) begin
        a = qa[idx]; b = qb[idx]; approx_sum = qap[idx];
      end else begin
        a = 8'($urandom); b = 8'($urandom); approx_sum = 8'($urandom);
      end
      if (v && e_rdy) begin
        ex = (int'(a) + int'(b)) % 256;
        ed = (ex > int'(approx_sum)) ? ex - int'(approx_sum) : int'(approx_sum) - ex;
        if (ed != 0) m_err++;
        if (ed > m_max) m_max = ed;
        m_sum += ed;
        idx++;
        acc++;
        if (acc == n) last = cyc;
      end
    end
    m_acc = acc;
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic clear_tables();
    qa.delete(); qb.delete(); qap.delete(); vpat.delete();
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({in_ready, busy, done, in_ready_s, busy_s, done_s} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got ready=%b busy=%b done=%b want 0", in_ready, busy, done);
    end
    vectors++;
    if (err_count !== 0 || max_ed !== 0 || sum_ed !== 0 || samples_seen !== 0 || sum_ed_s !== 0) begin
      miscompares++;
      $display("FAIL reset_results got err=%0d max=%0d sum=%0d seen=%0d want 0",
               err_count, max_ed, sum_ed, samples_seen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_exact();
    clear_tables();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(8'($urandom)); qb.push_back(8'($urandom));
      qap.push_back(qa[i] + qb[i]);
    end
    drive_run(4, 0, -1);
    vectors++;
    if (o_timeout != 0 || o_proto_bad != 0 || o_done_pulses != 1) begin
      miscompares++;
      $display("FAIL exact_proto got timeout=%0d bad=%0d pulses=%0d want 0 0 1",
               o_timeout, o_proto_bad, o_done_pulses);
    end
    vectors++;
    if (err_count !== 0 || max_ed !== 0 || sum_ed !== 0 || samples_seen !== 16'd4) begin
      miscompares++;
      $display("FAIL exact_results got err=%0d max=%0d sum=%0d seen=%0d want 0 0 0 4",
               err_count, max_ed, sum_ed, samples_seen);
    end
    $display("exact: 4 samples err=%0d max=%0d sum=%0d", err_count, max_ed, sum_ed);
  endtask

  task automatic test_mixed();
    clear_tables();
    qa = '{8'd200, 8'd200, 8'd200};
    qb = '{8'd100, 8'd100, 8'd100};
    qap = '{8'd40, 8'd50, 8'd44};
    drive_run(3, 0, -1);
    vectors++;
    if (o_timeout != 0 || o_proto_bad != 0 || o_done_pulses != 1 || o_lat != 2) begin
      miscompares++;
      $display("FAIL mixed_proto got timeout=%0d bad=%0d pulses=%0d lat=%0d want 0 0 1 2",
               o_timeout, o_proto_bad, o_done_pulses, o_lat);
    end
    vectors++;
    if (err_count !== 16'd2 || max_ed !== 8'd6 || sum_ed !== 24'd10 || sum_ed_s !== 8'd10) begin
      miscompares++;
      $display("FAIL mixed_results got err=%0d max=%0d sum=%0d sum8=%0d want 2 6 10 10",
               err_count, max_ed, sum_ed, sum_ed_s);
    end
    $display("mixed: err=%0d max=%0d sum=%0d lat=%0d", err_count, max_ed, sum_ed, o_lat);
  endtask

  task automatic test_backpressure();
    clear_tables();
    for (int i = 0; i < 3; i++) begin
      qa.push_back(8'($urandom)); qb.push_back(8'($urandom)); qap.push_back(8'($urandom));
    end
    vpat = '{1, 0, 0, 1, 0, 1};
    drive_run(3, 0, 2);
    vectors++;
    if (o_timeout != 0 || o_proto_bad != 0 || o_done_pulses != 1 || o_lat != 2) begin
      miscompares++;
      $display("FAIL backpressure_proto got timeout=%0d bad=%0d pulses=%0d lat=%0d want 0 0 1 2",
               o_timeout, o_proto_bad, o_done_pulses, o_lat);
    end
    vectors++;
    if (samples_seen !== 16'd3 || err_count !== 16'(m_err) || max_ed !== 8'(m_max)
        || sum_ed !== 24'(exp_sum(24))) begin
      miscompares++;
      $display("FAIL backpressure_results got seen=%0d err=%0d max=%0d sum=%0d want 3 %0d %0d %0d",
               samples_seen, err_count, max_ed, sum_ed, m_err, m_max, exp_sum(24));
    end
    $display("backpressure: seen=%0d err=%0d sum=%0d", samples_seen, err_count, sum_ed);
  endtask

  task automatic test_zero_length();
    clear_tables();
    drive_run(0, 0, -1);
    vectors++;
    if (o_timeout != 0 || o_proto_bad != 0 || o_done_pulses != 1 || o_lat != 2) begin
      miscompares++;
      $display("FAIL zero_proto got timeout=%0d bad=%0d pulses=%0d lat=%0d want 0 0 1 2",
               o_timeout, o_proto_bad, o_done_pulses, o_lat);
    end
    vectors++;
    if (err_count !== 0 || max_ed !== 0 || sum_ed !== 0 || samples_seen !== 0) begin
      miscompares++;
      $display("FAIL zero_results got err=%0d max=%0d sum=%0d seen=%0d want 0",
               err_count, max_ed, sum_ed, samples_seen);
    end
    $display("zero_length: done pulses=%0d", o_done_pulses);
  endtask

  task automatic test_saturation();
    clear_tables();
    qa = '{8'd0, 8'd0}; qb = '{8'd0, 8'd0}; qap = '{8'd255, 8'd255};
    drive_run(2, 20, -1);
    vectors++;
    if (o_timeout != 0 || o_proto_bad != 0 || o_done_pulses != 1) begin
      miscompares++;
      $display("FAIL sat_proto got timeout=%0d bad=%0d pulses=%0d want 0 0 1",
               o_timeout, o_proto_bad, o_done_pulses);
    end
    vectors++;
    if (sum_ed_s !== 8'd255 || max_ed_s !== 8'd255 || err_count_s !== 16'd2) begin
      miscompares++;
      $display("FAIL sat_narrow got sum=%0d max=%0d err=%0d want 255 255 2",
               sum_ed_s, max_ed_s, err_count_s);
    end
    vectors++;
    if (sum_ed !== 24'd510) begin
      miscompares++;
      $display("FAIL sat_wide got sum=%0d want 510", sum_ed);
    end
    $display("saturation: sum8=%0d sum24=%0d", sum_ed_s, sum_ed);
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    @(negedge clk);
    start = 1'b1; num_samples = 16'd10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); approx_sum = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (samples_seen !== 16'd5) begin
      miscompares++;
      $display("FAIL midrun_seen got %0d want 5", samples_seen);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, busy, done} !== 3'b0 || err_count !== 0 || max_ed !== 0 || sum_ed !== 0
        || samples_seen !== 0 || sum_ed_s !== 0) begin
      miscompares++;
      $display("FAIL midrun_reset got ready=%b busy=%b err=%0d max=%0d sum=%0d seen=%0d want 0",
               in_ready, busy, err_count, max_ed, sum_ed, samples_seen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || samples_seen !== 0) bad++;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midrun_idle got %0d bad idle cycles want 0", bad);
    end
    clear_tables();
    qa = '{8'd10, 8'd250}; qb = '{8'd20, 8'd10}; qap = '{8'd33, 8'd0};
    drive_run(2, 0, -1);
    vectors++;
    if (o_timeout != 0 || o_proto_bad != 0 || o_done_pulses != 1 || err_count !== 16'd2
        || max_ed !== 8'd4 || sum_ed !== 24'd7) begin
      miscompares++;
      $display("FAIL midrun_rerun got bad=%0d pulses=%0d err=%0d max=%0d sum=%0d want 0 1 2 4 7",
               o_proto_bad, o_done_pulses, err_count, max_ed, sum_ed);
    end
    $display("reset_mid_run: rerun err=%0d max=%0d sum=%0d", err_count, max_ed, sum_ed);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(20, 1);
      clear_tables();
      for (int i = 0; i < n; i++) begin
        logic [7:0] ta, tb;
        ta = 8'($urandom); tb = 8'($urandom);
        qa.push_back(ta); qb.push_back(tb);
        case ($urandom_range(2))
          0: qap.push_back(ta + tb);
          1: qap.push_back(ta + tb + 8'($urandom_range(7)) - 8'd3);
          default: qap.push_back(8'($urandom));
        endcase
      end
      drive_run(n, 35, -1);
      vectors++;
      if (o_timeout != 0 || o_proto_bad != 0 || o_done_pulses != 1 || o_lat != 2) begin
        miscompares++;
        $display("FAIL random_proto run=%0d got timeout=%0d bad=%0d pulses=%0d lat=%0d want 0 0 1 2",
                 r, o_timeout, o_proto_bad, o_done_pulses, o_lat);
      end
      vectors++;
      if (err_count !== 16'(m_err) || max_ed !== 8'(m_max) || sum_ed !== 24'(exp_sum(24))
          || sum_ed_s !== 8'(exp_sum(8)) || samples_seen !== 16'(n)) begin
        miscompares++;
        $display("FAIL random_results run=%0d got err=%0d max=%0d sum=%0d sum8=%0d seen=%0d want %0d %0d %0d %0d %0d",
                 r, err_count, max_ed, sum_ed, sum_ed_s, samples_seen,
                 m_err, m_max, exp_sum(24), exp_sum(8), n);
      end
      $display("random run %0d: n=%0d err=%0d max=%0d sum=%0d", r, n, err_count, max_ed, sum_ed);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_mixed();
    test_backpressure();
    test_zero_length();
    test_saturation();
    test_reset_mid_run();
    test_random_runs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/approx_error_monitor.md
# approx_error_monitor

Sequential error-metric stage that sits directly downstream of the N-bit ripple-carry approximate adders. It consumes each operand pair together with the approximate adder's N-bit sum and computes the exact N-bit sum internally. Over a programmed run of samples it accumulates the error count, the maximum error distance and the total error distance. It is the block used to characterise every approximate adder variant in simulation and on FPGA.

## Interface
- N, 8, operand and sum width; must match the adder under test
- CNT_W, 16, width of the sample counter and of err_count
- ACC_W, 24, width of the sum_ed accumulator; must be ≥ N

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begins a run; sampled only in IDLE
- num_samples  in  CNT_W  samples in the run; latched when start is accepted
- in_valid  in  1  a, b and approx_sum are valid this cycle
- in_ready  out  1  monitor accepts a sample this cycle
- a  in  N  operand A as fed to the adder
- b  in  N  operand B as fed to the adder
- approx_sum  in  N  sum produced by the approximate adder
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when results are final
- err_count  out  CNT_W  samples with nonzero error distance
- max_ed  out  N  largest error distance in the run
- sum_ed  out  ACC_W  total error distance, saturating
- samples_seen  out  CNT_W  samples accepted so far in the run

## Operation
- Exact reference: exact = (a + b) mod 2^N. The carry-out is discarded, because the adder under test also produces only N bits.
- Error distance: ED = |exact − approx_sum|, an N-bit unsigned magnitude. A sample is an error when ED ≠ 0.
- The FSM has four states: IDLE, RUN, DRAIN and DONE.
  - IDLE: in_ready=0 and busy=0.
    - start=1 with num_samples≠0: latch num_samples, clear every result register, go to RUN.
    - start=1 with num_samples=0: clear every result register, go to DONE.
  - RUN: in_ready=1 and busy=1.
    - A sample is accepted when in_valid && in_ready.
    - Each acceptance increments samples_seen.
    - If the acceptance is the num_samples-th, go to DRAIN.
  - DRAIN: in_ready=0 and busy=1. Wait one cycle for the last accumulation, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- The datapath has two stages.
  - Stage 1: on acceptance, register ED and an error flag, together with a stage-1 valid bit.
  - Stage 2: when the stage-1 valid bit is set:
    - err_count += flag
    - max_ed = max(max_ed, ED)
    - sum_ed = min(sum_ed + ED, 2^ACC_W − 1)
- start is ignored outside IDLE.
- in_valid is ignored when in_ready=0.
- Results hold their values from DONE until the next accepted start.
- err_count cannot overflow because it is bounded by num_samples.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, busy=0, done=0
  - err_count=0, max_ed=0, sum_ed=0, samples_seen=0
  - stage-1 valid bit=0
- The start→RUN transition takes one edge. in_ready rises in the cycle after start is sampled.
- Throughput is one sample per cycle. in_valid gaps stall progress without losing state.
- Latency runs from the accepting edge k of a sample:
  - its ED is registered at edge k;
  - it is reflected in the outputs after edge k+1.
- When the last sample is accepted at edge k:
  - the FSM is in DRAIN for cycle k→k+1;
  - done is high for cycle k+1→k+2;
  - the FSM returns to IDLE at edge k+2.
- With num_samples=0, done pulses in the cycle after the start edge and all results read 0.
- An rst_n assertion mid-run returns everything to its reset value immediately, with no done pulse. A new start is required afterwards.

## Test plan
- Exact adder: N=8, num_samples=4, approx_sum=(a+b) mod 256 for all samples → done pulses exactly once, err_count=0, max_ed=0, sum_ed=0, samples_seen=4.
- Mixed errors: three samples with a=200, b=100 (exact 44):
  - inputs: approx_sum=40, then 50, then 44;
  - expected: err_count=2, max_ed=6, sum_ed=10;
  - done pulses 2 cycles after the third acceptance edge.
- Backpressure and ignore: num_samples=3, in_valid toggled 1,0,0,1,0,1, plus a start pulse during RUN → exactly 3 samples accepted, the start has no effect, in_ready drops in DRAIN.
- Zero-length run: start with num_samples=0 → done in the cycle after start, all results 0, in_ready never asserted.
- Saturation: ACC_W=8, N=8, two samples with a=0, b=0, approx_sum=255 (ED=255 each) → sum_ed=255 (saturated), max_ed=255, err_count=2.
- Reset mid-run: num_samples=10, assert rst_n low after 5 acceptances → all outputs read 0 and state is IDLE with no done pulse. A subsequent run with num_samples=2 completes correctly.
